// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory read port and decoder valid/ready channel.
// INST_FETCH_TRACE_EN adds inst_pc alongside inst_data.
interface inst_fetch_ctrl_if #(
  parameter int unsigned INST_LEN = 16,
  parameter int unsigned PC_WIDTH = 8
);
  logic                imem_en;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [INST_LEN-1:0] imem_rdata;
  logic                inst_valid;
  logic [INST_LEN-1:0] inst_data;
  logic                inst_ready;
`ifdef INST_FETCH_TRACE_EN
  logic [PC_WIDTH-1:0] inst_pc;
`endif

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    output inst_valid, inst_data,
`ifdef INST_FETCH_TRACE_EN
    output inst_pc,
`endif
    input  inst_ready
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    input  inst_valid, inst_data,
`ifdef INST_FETCH_TRACE_EN
    input  inst_pc,
`endif
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: reads imem at the launcher PC, buffers words in a 2-entry
// fall-through FIFO and issues them to the decoder. INST_FETCH_TRACE_EN adds per-entry PC.
module inst_fetch_ctrl #(
  parameter int unsigned          INST_LEN   = 16,
  parameter int unsigned          PC_WIDTH   = 8,
  parameter int unsigned          OP_WIDTH   = 4,
  parameter logic [OP_WIDTH-1:0]  END_OPCODE = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] PC,
  output logic                is_working,
  output logic                complete,
  output logic                busy,
  output logic                pc_ovf,
  inst_fetch_ctrl_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [PC_WIDTH-1:0] PC_MAX = '1;

  state_t              state, state_nx;
  logic [1:0]          count;
  logic                rd_pend;
  logic                wr_ptr, rd_ptr;
  logic [INST_LEN-1:0] fifo_data [2];
  logic                fetch, push, push_ok, pop, pop_fifo, wr, bypass, rdata_end;

`ifdef INST_FETCH_TRACE_EN
  logic [PC_WIDTH-1:0] rd_pc;
  logic [PC_WIDTH-1:0] fifo_pc [2];
`endif

  assign rdata_end = (bus.imem_rdata[INST_LEN-1 -: OP_WIDTH] == END_OPCODE);

  // The END-return cycle still issues a credit-gated fetch; that word lands in DRAIN and is dropped.
  always_comb begin
    state_nx = state;
    fetch    = 1'b0;
    push     = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        fetch = ((count + {1'b0, rd_pend}) < 2'd2) && !pc_ovf;
        if (rd_pend) begin
          if (rdata_end) begin
            state_nx = DRAIN;
          end else begin
            push = 1'b1;
            if (pc_ovf) state_nx = DRAIN;
          end
        end
      end
      DRAIN: if (count == 2'd0 && !rd_pend) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign is_working    = fetch;
  assign bus.imem_en   = fetch;
  assign bus.imem_addr = PC;
  assign complete      = (state == DONE);
  assign busy          = (state != IDLE);

  // Empty FIFO forwards the returning word straight to the head; it is only stored if not taken.
  assign bypass         = push && (count == 2'd0);
  assign bus.inst_valid = (count != 2'd0) || push;
  assign bus.inst_data  = bypass ? bus.imem_rdata : fifo_data[rd_ptr];
  assign pop            = bus.inst_valid && bus.inst_ready;
  assign pop_fifo       = pop && (count != 2'd0);
  assign push_ok        = push && ((count != 2'd2) || pop);
  assign wr             = push_ok && !(bypass && pop);

`ifdef INST_FETCH_TRACE_EN
  assign bus.inst_pc = bypass ? rd_pc : fifo_pc[rd_ptr];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      rd_pend      <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      pc_ovf       <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
`ifdef INST_FETCH_TRACE_EN
      rd_pc        <= '0;
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
`endif
    end else begin
      state   <= state_nx;
      rd_pend <= fetch;
      if (state == IDLE && start) pc_ovf <= 1'b0;
      else if (fetch && PC == PC_MAX) pc_ovf <= 1'b1;
      if (wr) begin
        fifo_data[wr_ptr] <= bus.imem_rdata;
`ifdef INST_FETCH_TRACE_EN
        fifo_pc[wr_ptr]   <= rd_pc;
`endif
        wr_ptr <= ~wr_ptr;
      end
      if (pop_fifo) rd_ptr <= ~rd_ptr;
      unique case ({wr, pop_fifo})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
`ifdef INST_FETCH_TRACE_EN
      if (fetch) rd_pc <= PC;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl (PC_WIDTH=3): ROM, PC launcher and an
// expected-word scoreboard derived from the ROM contents; directed plus random programs.
module tb_inst_fetch_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] pc;
  logic       is_working, complete, busy, pc_ovf;

  inst_fetch_ctrl_if #(.INST_LEN(16), .PC_WIDTH(3)) bus ();

  inst_fetch_ctrl #(.INST_LEN(16), .PC_WIDTH(3), .OP_WIDTH(4), .END_OPCODE(4'hF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .PC         (pc),
    .is_working (is_working),
    .complete   (complete),
    .busy       (busy),
    .pc_ovf     (pc_ovf),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [8];

  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst)             pc <= '0;
    else if (complete)   pc <= '0;
    else if (is_working) pc <= pc + 3'd1;
  end

  int unsigned checks = 0, failures = 0;
  int unsigned ready_pct = 100;
  int unsigned iw_cnt, cpl_cnt;
  logic [15:0] exp_q [$];
  logic [2:0]  exp_pc_q [$];
  bit          exp_ovf;
  bit          prev_hold;
  logic [15:0] prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected program output: words in address order up to the first END; none -> overflow.
  task automatic build_exp();
    exp_q.delete();
    exp_pc_q.delete();
    exp_ovf = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rom[i][15:12] == 4'hF) begin
        exp_ovf = 1'b0;
        break;
      end
      exp_q.push_back(rom[i]);
      exp_pc_q.push_back(3'(i));
    end
  endtask

  task automatic monitor();
    logic [2:0] epc;
    check("imem_addr", {29'd0, bus.imem_addr}, {29'd0, pc});
    check("iw_cpl_excl", {31'd0, is_working & complete}, 32'd0);
    check("iw_eq_en", {31'd0, is_working}, {31'd0, bus.imem_en});
    if (bus.inst_valid) check("end_not_valid", {28'd0, bus.inst_data[15:12]} == 32'hF, 32'd0);
    if (prev_hold) begin
      check("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
      check("hold_data", {16'd0, bus.inst_data}, {16'd0, prev_data});
    end
    if (bus.inst_valid && bus.inst_ready) begin
      check("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        check("word", {16'd0, bus.inst_data}, {16'd0, exp_q.pop_front()});
        epc = exp_pc_q.pop_front();
`ifdef INST_FETCH_TRACE_EN
        check("inst_pc", {29'd0, bus.inst_pc}, {29'd0, epc});
`endif
      end
    end
    iw_cnt    += is_working;
    cpl_cnt   += complete;
    prev_hold = bus.inst_valid && !bus.inst_ready;
    prev_data = bus.inst_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.inst_ready = ($urandom_range(0, 99) < ready_pct);
    #1;
    monitor();
  endtask

  task automatic begin_prog();
    build_exp();
    iw_cnt    = 0;
    cpl_cnt   = 0;
    prev_hold = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("ovf_cleared", {31'd0, pc_ovf}, 32'd0);
  endtask

  task automatic wait_done(input int unsigned mid_start_at, output int unsigned cyc);
    bit done;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 300) begin
      start = (mid_start_at != 0 && cyc + 1 == mid_start_at);
      tick();
      cyc++;
      if (complete) done = 1'b1;
    end
    start = 1'b0;
    check("complete_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic finish_prog();
    tick();
    check("complete_single", {31'd0, complete}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("pc_cleared", {29'd0, pc}, 32'd0);
    check("all_delivered", exp_q.size(), 32'd0);
    check("pc_ovf", {31'd0, pc_ovf}, {31'd0, exp_ovf});
    check("complete_count", cpl_cnt, 32'd1);
  endtask

  task automatic rom_basic();
    rom[0] = 16'h1001;
    rom[1] = 16'h2002;
    rom[2] = 16'hF000;
    for (int i = 3; i < 8; i++) rom[i] = 16'h3000 + 16'(i);
  endtask

  initial begin
    int unsigned cyc;
    rst = 1'b1;
    start = 1'b0;
    bus.inst_ready = 1'b0;
    rom_basic();
    repeat (2) @(posedge clk);
    #1;
    check("rst_is_working", {31'd0, is_working}, 32'd0);
    check("rst_complete", {31'd0, complete}, 32'd0);
    check("rst_imem_en", {31'd0, bus.imem_en}, 32'd0);
    check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, pc_ovf}, 32'd0);
    check("rst_data", {16'd0, bus.inst_data}, 32'd0);
    rst = 1'b0;

    // Basic program, with a start pulse while busy that must be ignored
    ready_pct = 100;
    begin_prog();
    wait_done(2, cyc);
    finish_prog();

    // Decoder stalled for 10 cycles
    ready_pct = 0;
    begin_prog();
    repeat (9) tick();
    check("stall_fetch_pulses", {31'd0, iw_cnt <= 2}, 32'd1);
    check("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("stall_head", {16'd0, bus.inst_data}, 32'h1001);
    ready_pct = 100;
    wait_done(0, cyc);
    finish_prog();

    // No END: full address space then overflow
    for (int i = 0; i < 8; i++) rom[i] = 16'h4000 + 16'(i * 16'h0111);
    ready_pct = 60;
    begin_prog();
    wait_done(0, cyc);
    finish_prog();
    rom_basic();
    ready_pct = 100;
    begin_prog();
    wait_done(0, cyc);
    finish_prog();

    // END at address 0
    rom[0] = 16'hF123;
    begin_prog();
    wait_done(0, cyc);
    check("end0_latency", {31'd0, cyc <= 4}, 32'd1);
    finish_prog();

    // Async reset with a full FIFO
    rom_basic();
    ready_pct = 0;
    begin_prog();
    repeat (6) tick();
    check("full_valid", {31'd0, bus.inst_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_is_working", {31'd0, is_working}, 32'd0);
    check("arst_imem_en", {31'd0, bus.imem_en}, 32'd0);
    check("arst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_complete", {31'd0, complete}, 32'd0);
    check("arst_data", {16'd0, bus.inst_data}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ready_pct = 100;
    begin_prog();
    wait_done(0, cyc);
    finish_prog();

    // Random programs and decoder back-pressure
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 8; i++) rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      if ($urandom_range(0, 4) != 0) rom[$urandom_range(0, 4)] = {4'hF, 12'($urandom)};
      ready_pct = $urandom_range(20, 100);
      begin_prog();
      wait_done($urandom_range(0, 3), cyc);
      finish_prog();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
